// File: rtl/sum_serial_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package sum_serial_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_serial_ctrl_if.sv
// Request/result bundle between the front-end (master) and the serial controller (slave).
interface sum_serial_ctrl_if import sum_serial_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             overflow;

    modport master (
        output start, sub, A, B,
        input  busy, done, S, Cout, overflow
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, S, Cout, overflow
    );
endinterface

// File: rtl/sum1bcc_primitive.sv
// Single-bit full adder cell shared across all bit positions.
module sum1bcc_primitive (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Ci;
    assign Cout = (A & B) | (Ci & (A ^ B));
endmodule

// File: rtl/sum_serial_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walks the operands LSB first,
// carry is held in a register between cycles, result is shifted in from the top.
module sum_serial_ctrl import sum_serial_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic               clk,
    input logic               rst,
    sum_serial_ctrl_if.slave  bus
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_PEN  = CNT_W'(WIDTH - 2);

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_sh, b_sh, s_reg;
    logic [CNT_W-1:0]  cnt;
    logic              carry, carry_msb_in;
    logic              sum_bit, carry_next;
    logic              busy, done;

    sum1bcc_primitive u_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Ci   (carry),
        .S    (sum_bit),
        .Cout (carry_next)
    );

    // State register; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_next = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand shifters, carry, bit counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh         <= '0;
            b_sh         <= '0;
            s_reg        <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            carry_msb_in <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                    a_sh  <= bus.A;
                    b_sh  <= bus.sub ? ~bus.B : bus.B;
                    carry <= bus.sub;
                    cnt   <= '0;
                    s_reg <= '0;
                end
                SHIFT: begin
                    s_reg <= {sum_bit, s_reg[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_next;
                    // Hold at the last count so the counter never wraps.
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CNT_PEN) carry_msb_in <= carry_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.S        = s_reg;
    assign bus.Cout     = carry;
    assign bus.overflow = carry_msb_in ^ carry;

endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Self-checking bench: directed cases plus randomized operations against an
// arithmetic reference model.
module tb_sum_serial_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sum_serial_ctrl_if #(.WIDTH(W)) bus();
    sum_serial_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic and sign rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int unsigned ua, ub;
        ua = a;
        ub = b;
        if (!s) begin
            r = W'(ua + ub);
            c = (ua + ub) >= (1 << W);
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = W'(ua - ub);
            c = ua >= ub;
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
    endfunction

    // One operation; poke re-asserts start mid-SHIFT, rst_at aborts with reset (0 = off).
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input int poke, input int rst_at);
        logic [W-1:0] er;
        logic         ec, ev;
        int           lat, bcnt, nd;
        bit           seen;
        model(a, b, s, er, ec, ev);
        @(negedge clk);
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.sub = s;
        @(negedge clk);
        bus.start = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom); bus.sub = 1'($urandom);
        lat = 1; bcnt = 0; seen = 0;
        while (lat <= W + 4) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin seen = 1; break; end
            bus.start = (lat == poke);
            if (lat == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", bus.busy, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_S", bus.S, 0);
                chk("rst_cout", bus.Cout, 0);
                chk("rst_ovf", bus.overflow, 0);
                nd = 0;
                for (int i = 0; i < W + 4; i++) begin
                    @(negedge clk);
                    if (bus.done) nd++;
                end
                chk("rst_nodone", nd, 0);
                return;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", lat, W + 1);
        chk("busy_cycles", bcnt, W + 1);
        chk("S", bus.S, er);
        chk("Cout", bus.Cout, ec);
        chk("ovf", bus.overflow, ev);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("S_held", bus.S, er);
        chk("Cout_held", bus.Cout, ec);
        chk("ovf_held", bus.overflow, ev);
    endtask

    initial begin
        logic [W-1:0] er;
        logic         ec, ev;
        int           last, nd;
        bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_S", bus.S, 0);
        chk("reset_cout", bus.Cout, 0);
        chk("reset_ovf", bus.overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        op(8'h0F, 8'h01, 1'b0, 0, 0);
        op(8'hFF, 8'h01, 1'b0, 0, 0);
        op(8'h7F, 8'h01, 1'b0, 0, 0);
        op(8'h40, 8'h40, 1'b0, 0, 0);
        op(8'h05, 8'h07, 1'b1, 0, 0);
        op(8'h80, 8'h01, 1'b1, 0, 0);
        op(8'h33, 8'h00, 1'b1, 0, 0);
        op(8'h12, 8'h34, 1'b0, 3, 0);
        op(8'h5A, 8'hA5, 1'b0, 0, 4);
        op(8'h21, 8'h43, 1'b1, 0, 0);

        // start held high: one operation every W+2 cycles.
        model(8'h9C, 8'h3B, 1'b1, er, ec, ev);
        @(negedge clk);
        bus.start = 1'b1; bus.A = 8'h9C; bus.B = 8'h3B; bus.sub = 1'b1;
        last = 0; nd = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                chk("b2b_S", bus.S, er);
                chk("b2b_Cout", bus.Cout, ec);
                if (last > 0) chk("b2b_period", i - last, W + 2);
                else          chk("b2b_first", i, W + 1);
                last = i;
            end
        end
        bus.start = 1'b0;
        chk("b2b_count", nd, 4);
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
        chk("b2b_idle", bus.busy, 0);

        for (int k = 0; k < 20; k++)
            op(W'($urandom), W'($urandom), 1'($urandom), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
